dmi_jtag_master: RTL

DMI_JTAG_MASTER -- requirements
Module: dmi_jtag_master

---
 rtl/dmi_jtag_master.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dmi_jtag_master.sv
// JTAG scan master: turns TAP-reset / IR-scan / DR-scan commands into TCK/TMS/TDI
// sequences and returns the captured TDO bits through a valid/ready response.
module dmi_jtag_master #(
    parameter int ClkDiv = 2,
    parameter int MaxLen = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [6:0]        req_len_i,
    input  logic [MaxLen-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [MaxLen-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PRE   = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] POST  = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    localparam logic [1:0] OP_RST = 2'd0;
    localparam logic [1:0] OP_IR  = 2'd1;
    localparam logic [1:0] OP_DR  = 2'd2;

    localparam int PW = $clog2(2 * ClkDiv);
    localparam int IW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(2 * ClkDiv - 1);
    localparam logic [PW-1:0] PH_RISE = PW'(ClkDiv);
    localparam logic [7:0]    MAX_LEN = 8'(MaxLen);

    logic [2:0]        state_q, state_d;
    logic [PW-1:0]     ph_q, ph_d;
    logic [6:0]        bit_q, bit_d;
    logic [1:0]        op_q, op_d;
    logic [6:0]        len_q, len_d;
    logic [MaxLen-1:0] data_q, data_d;
    logic [MaxLen-1:0] cap_q, cap_d;
    logic              err_q, err_d;
    logic              tck_q, tck_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;

    logic              accept_s;
    logic              illegal_s;
    logic              bit_end_s;
    logic              active_d_s;
    logic [5:0]        pre_pat_s;
    logic [6:0]        pre_last_s;

    assign req_ready_o = ready_q;
    assign rsp_valid_o = valid_q;
    assign rsp_data_o  = cap_q;
    assign rsp_err_o   = err_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

    // Next-state, counters and pin values; pins are derived from the next state so they register cleanly.
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        bit_d      = bit_q;
        op_d       = op_q;
        len_d      = len_q;
        data_d     = data_q;
        cap_d      = cap_q;
        err_d      = err_q;
        pre_pat_s  = 6'b000000;
        pre_last_s = 7'd0;
        tms_d      = 1'b0;
        tdi_d      = 1'b0;

        accept_s  = ready_q && req_valid_i;
        illegal_s = (req_op_i == 2'd3) ||
                    ((req_op_i != OP_RST) && ((req_len_i == 7'd0) || ({1'b0, req_len_i} > MAX_LEN)));
        bit_end_s = (ph_q == PH_LAST);

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    op_d   = req_op_i;
                    len_d  = req_len_i;
                    data_d = req_data_i;
                    cap_d  = '0;
                    ph_d   = '0;
                    bit_d  = 7'd0;
                    err_d  = illegal_s;
                    state_d = illegal_s ? RESP : PRE;
                end else begin
                    state_d = IDLE;
                end
            end
            PRE, SHIFT, POST: begin
                ph_d = bit_end_s ? '0 : PW'(ph_q + PW'(1));
                if ((state_q == SHIFT) && (ph_q == PH_RISE)) begin
                    cap_d[bit_q[IW-1:0]] = tdo_i;
                end else begin
                    cap_d = cap_q;
                end
                if (bit_end_s) begin
                    bit_d = 7'(bit_q + 7'd1);
                    if (state_q == PRE) begin
                        if (bit_q == ((op_q == OP_RST) ? 7'd5 : (op_q == OP_IR) ? 7'd3 : 7'd2)) begin
                            bit_d   = 7'd0;
                            state_d = (op_q == OP_RST) ? RESP : SHIFT;
                        end else begin
                            state_d = PRE;
                        end
                    end else if (state_q == SHIFT) begin
                        if (bit_q == 7'(len_q - 7'd1)) begin
                            bit_d   = 7'd0;
                            state_d = POST;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        state_d = (bit_q == 7'd1) ? RESP : POST;
                    end
                end else begin
                    bit_d = bit_q;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // TMS patterns before SHIFT, bit 0 sent first, all starting from Run-Test/Idle
        case (op_d)
            OP_RST:  begin pre_pat_s = 6'b011111; pre_last_s = 7'd5; end
            OP_IR:   begin pre_pat_s = 6'b000011; pre_last_s = 7'd3; end
            OP_DR:   begin pre_pat_s = 6'b000001; pre_last_s = 7'd2; end
            default: begin pre_pat_s = 6'b000000; pre_last_s = 7'd0; end
        endcase

        case (state_d)
            PRE:     tms_d = (bit_d <= pre_last_s) ? pre_pat_s[bit_d[2:0]] : 1'b0;
            SHIFT:   tms_d = (bit_d == 7'(len_d - 7'd1));
            POST:    tms_d = (bit_d == 7'd0);
            default: tms_d = 1'b0;
        endcase

        if (state_d == SHIFT) begin
            tdi_d = data_d[bit_d[IW-1:0]];
        end else begin
            tdi_d = 1'b0;
        end

        active_d_s = (state_d == PRE) || (state_d == SHIFT) || (state_d == POST);
        tck_d      = active_d_s && (ph_d >= PH_RISE);
        valid_d    = (state_d == RESP);
        ready_d    = (state_d == IDLE);
    end

    // State and output registers with synchronous reset that aborts any scan in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ph_q    <= '0;
            bit_q   <= 7'd0;
            op_q    <= 2'd0;
            len_q   <= 7'd0;
            data_q  <= '0;
            cap_q   <= '0;
            err_q   <= 1'b0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b0;
            tdi_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            op_q    <= op_d;
            len_q   <= len_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

endmodule
